// File: rtl/cmul_arbiter.sv
// cmul_arbiter: round-robin arbiter feeding two requesters into one shared
// 2-stage complex multiplier (S1 operands, S2 result) with full backpressure.
module cmul_arbiter #(
  parameter int WIDTH = 16,
  parameter int TAGW  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    r0_valid,
  output logic                    r0_ready,
  input  logic signed [WIDTH-1:0] r0_a_re,
  input  logic signed [WIDTH-1:0] r0_a_im,
  input  logic signed [WIDTH-1:0] r0_b_re,
  input  logic signed [WIDTH-1:0] r0_b_im,
  input  logic [TAGW-1:0]         r0_tag,
  input  logic                    r1_valid,
  output logic                    r1_ready,
  input  logic signed [WIDTH-1:0] r1_a_re,
  input  logic signed [WIDTH-1:0] r1_a_im,
  input  logic signed [WIDTH-1:0] r1_b_re,
  input  logic signed [WIDTH-1:0] r1_b_im,
  input  logic [TAGW-1:0]         r1_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic [TAGW-1:0]         out_tag,
  output logic                    out_src
);
  logic v1, last_grant, any, gnt, adv1, adv2, src1;
  logic signed [WIDTH-1:0] a_re, a_im, b_re, b_im;
  logic [TAGW-1:0] tag1;
  logic signed [2*WIDTH-1:0] rr, ii, ri, ir;
  assign any  = r0_valid || r1_valid;
  // on a tie the requester not granted last wins
  assign gnt  = (r0_valid && r1_valid) ? !last_grant : r1_valid;
  assign adv2 = !out_valid || out_ready;
  assign adv1 = !v1 || adv2;
  assign r0_ready = rst_n && adv1 && r0_valid && !gnt;
  assign r1_ready = rst_n && adv1 && r1_valid && gnt;
  assign rr = a_re * b_re;
  assign ii = a_im * b_im;
  assign ri = a_re * b_im;
  assign ir = a_im * b_re;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      last_grant <= 1'b1;
      a_re       <= '0;
      a_im       <= '0;
      b_re       <= '0;
      b_im       <= '0;
      tag1       <= '0;
      src1       <= 1'b0;
      out_valid  <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
      out_tag    <= '0;
      out_src    <= 1'b0;
    end else begin
      if (adv1) begin
        v1 <= any;
        if (any) begin
          a_re       <= gnt ? r1_a_re : r0_a_re;
          a_im       <= gnt ? r1_a_im : r0_a_im;
          b_re       <= gnt ? r1_b_re : r0_b_re;
          b_im       <= gnt ? r1_b_im : r0_b_im;
          tag1       <= gnt ? r1_tag : r0_tag;
          src1       <= gnt;
          last_grant <= gnt;
        end
      end
      if (adv2) begin
        out_valid <= v1;
        if (v1) begin
          out_re  <= WIDTH'(rr >>> (WIDTH-1)) - WIDTH'(ii >>> (WIDTH-1));
          out_im  <= WIDTH'(ri >>> (WIDTH-1)) + WIDTH'(ir >>> (WIDTH-1));
          out_tag <= tag1;
          out_src <= src1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cmul_arbiter.sv
// tb_cmul_arbiter: directed corner cases plus randomized traffic checked
// against a queue-based scoreboard and a round-robin grant model.
module tb_cmul_arbiter;
  logic clk = 0, rst_n = 0;
  logic r0_valid = 0, r1_valid = 0, r0_ready, r1_ready, out_ready = 0;
  logic [15:0] r0_a_re = 0, r0_a_im = 0, r0_b_re = 0, r0_b_im = 0;
  logic [15:0] r1_a_re = 0, r1_a_im = 0, r1_b_re = 0, r1_b_im = 0;
  logic [5:0] r0_tag = 0, r1_tag = 0, out_tag;
  logic out_valid, out_src;
  logic [15:0] out_re, out_im;
  typedef struct packed {logic [15:0] re, im; logic [5:0] tag; logic src;} res_t;
  res_t exp_q[$];
  res_t h;
  int n_chk = 0, n_err = 0, p_val = 0, p_rdy = 0;
  logic mlg = 1, held = 0, hs0 = 0, hs1 = 0, rd0 = 0, rd1 = 0;
  cmul_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a_re(r0_a_re), .r0_a_im(r0_a_im),
    .r0_b_re(r0_b_re), .r0_b_im(r0_b_im), .r0_tag(r0_tag),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a_re(r1_a_re), .r1_a_im(r1_a_im),
    .r1_b_re(r1_b_re), .r1_b_im(r1_b_im), .r1_tag(r1_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_tag(out_tag), .out_src(out_src)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic res_t model(input logic [15:0] ar, ai, br, bi, input logic [5:0] tg, input logic s);
    longint rr, ii, ri, ir, re, im;
    res_t r;
    rr = (longint'($signed(ar)) * longint'($signed(br))) >>> 15;
    ii = (longint'($signed(ai)) * longint'($signed(bi))) >>> 15;
    ri = (longint'($signed(ar)) * longint'($signed(bi))) >>> 15;
    ir = (longint'($signed(ai)) * longint'($signed(br))) >>> 15;
    re = rr - ii;
    im = ri + ir;
    r.re = re[15:0];
    r.im = im[15:0];
    r.tag = tg;
    r.src = s;
    return r;
  endfunction
  function automatic logic [15:0] rv();
    int k = $urandom_range(0, 7);
    return k == 0 ? 16'h8000 : k == 1 ? 16'h7FFF : k == 2 ? 16'h4000 :
           k == 3 ? 16'hFFFF : k == 4 ? 16'h0000 : 16'($urandom);
  endfunction
  task automatic refresh();
    if (hs0 || !r0_valid) begin
      r0_valid = $urandom_range(0, 99) < p_val;
      r0_a_re = rv(); r0_a_im = rv(); r0_b_re = rv(); r0_b_im = rv();
      r0_tag = 6'($urandom);
    end
    if (hs1 || !r1_valid) begin
      r1_valid = $urandom_range(0, 99) < p_val;
      r1_a_re = rv(); r1_a_im = rv(); r1_b_re = rv(); r1_b_im = rv();
      r1_tag = 6'($urandom);
    end
    out_ready = $urandom_range(0, 99) < p_rdy;
  endtask
  task automatic step();
    res_t e;
    logic w;
    #1;
    rd0 = r0_ready; rd1 = r1_ready;
    hs0 = r0_valid && r0_ready;
    hs1 = r1_valid && r1_ready;
    chk("both_ready", r0_ready && r1_ready, 0);
    if (r0_ready || r1_ready) begin
      w = (r0_valid && r1_valid) ? ~mlg : r1_valid;
      chk("grant_src", r1_ready, w);
      chk("grant_valid", r1_ready ? r1_valid : r0_valid, 1);
    end
    if (held) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", {out_re, out_im, out_tag, out_src}, h);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("out_re", out_re, e.re);
        chk("out_im", out_im, e.im);
        chk("out_tag", out_tag, e.tag);
        chk("out_src", out_src, e.src);
      end
    end
    if (hs0) begin exp_q.push_back(model(r0_a_re, r0_a_im, r0_b_re, r0_b_im, r0_tag, 0)); mlg = 0; end
    if (hs1) begin exp_q.push_back(model(r1_a_re, r1_a_im, r1_b_re, r1_b_im, r1_tag, 1)); mlg = 1; end
    held = out_valid && !out_ready;
    h = {out_re, out_im, out_tag, out_src};
    @(posedge clk); #1;
    refresh();
  endtask
  task automatic do_reset();
    rst_n = 0; r0_valid = 0; r1_valid = 0; out_ready = 0;
    hs0 = 0; hs1 = 0; held = 0; mlg = 1; exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", {out_re, out_im, out_tag, out_src}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic single(input logic who, input logic [15:0] ar, ai, br, bi, input logic [5:0] tg,
                        input logic [15:0] er, ei, input string nm);
    r0_a_re = ar; r0_a_im = ai; r0_b_re = br; r0_b_im = bi; r0_tag = tg;
    r1_a_re = ar; r1_a_im = ai; r1_b_re = br; r1_b_im = bi; r1_tag = tg;
    r0_valid = !who; r1_valid = who; out_ready = 1;
    #1 chk({nm, "_rdy"}, who ? r1_ready : r0_ready, 1);
    @(posedge clk); #1;
    r0_valid = 0; r1_valid = 0;
    chk({nm, "_early"}, out_valid, 0);
    @(posedge clk); #1;
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_re"}, out_re, er);
    chk({nm, "_im"}, out_im, ei);
    chk({nm, "_tag"}, out_tag, tg);
    chk({nm, "_src"}, out_src, who);
    @(posedge clk); #1;
    mlg = who;
  endtask
  initial begin
    int n;
    do_reset();
    single(0, 16'h4000, 0, 16'h4000, 0, 6'd5, 16'h2000, 16'h0000, "half_sq");
    single(1, 0, 16'h4000, 0, 16'h4000, 6'd9, 16'hE000, 16'h0000, "imag_sq");
    single(1, 16'h7FFF, 0, 16'h7FFF, 0, 6'd17, 16'h7FFE, 16'h0000, "max_sq");
    single(0, 16'h8000, 0, 16'h8000, 0, 6'd33, 16'h8000, 16'h0000, "wrap");
    single(0, 16'h4000, 16'h4000, 16'h4000, 16'hC000, 6'd2, 16'h4000, 16'h0000, "conj");
    // both requesters continuously valid: strict alternation starting at r0
    do_reset();
    p_val = 100; p_rdy = 100; hs0 = 0; hs1 = 0;
    refresh();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_hs", hs0 | hs1, 1);
      chk("rr_src", hs1, i % 2);
    end
    p_val = 0;
    repeat (8) step();
    chk("rr_drain", exp_q.size(), 0);
    // downstream stalled: only two pairs fit in the pipeline
    do_reset();
    p_val = 100; p_rdy = 0; hs0 = 0; hs1 = 0;
    refresh();
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n += int'(hs0) + int'(hs1);
      if (i >= 2) chk("stall_rdy", rd0 | rd1, 0);
    end
    chk("stall_accepts", n, 2);
    p_rdy = 100; p_val = 0;
    repeat (8) step();
    chk("stall_drain", exp_q.size(), 0);
    // randomized traffic with random backpressure
    do_reset();
    p_val = 70; p_rdy = 70; hs0 = 0; hs1 = 0;
    refresh();
    repeat (3000) step();
    p_val = 0; p_rdy = 100;
    repeat (12) step();
    chk("rand_drain", exp_q.size(), 0);
    // reset with both stages full
    do_reset();
    p_val = 100; p_rdy = 0; hs0 = 0; hs1 = 0;
    refresh();
    repeat (3) step();
    #2 rst_n = 0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_rdy", r0_ready | r1_ready, 0);
    chk("midrst_data", {out_re, out_im, out_tag}, 0);
    r0_valid = 1; r1_valid = 1; r0_tag = 6'd11; r1_tag = 6'd12; out_ready = 1;
    @(negedge clk); rst_n = 1;
    #1;
    chk("post_rst_r0", r0_ready, 1);
    chk("post_rst_r1", r1_ready, 0);
    @(posedge clk); #1;
    r0_valid = 0; r1_valid = 0;
    @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_src", out_src, 0);
    chk("post_rst_tag", out_tag, 6'd11);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
